// File: rtl/bram_burst_reader_if.sv
// Signal bundle between the burst reader, its BRAM port and the beat consumer.
// The bundle also carries the burst request and status signals.
interface bram_burst_reader_if #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 9
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  beat_len;
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [63:0]       bram_rdata;
    logic [31:0]       m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic              busy;
    logic              done;

    // A beat transfers on a rising edge where m_tvalid & m_tready. Once m_tvalid is
    // high, m_tdata/m_tlast stay unchanged until that transfer; m_tvalid never depends on m_tready.
    modport master (
        input  start, base_addr, beat_len, bram_rdata, m_tready,
        output bram_en, bram_addr, m_tdata, m_tvalid, m_tlast, busy, done
    );

    modport slave (
        output start, base_addr, beat_len, bram_rdata, m_tready,
        input  bram_en, bram_addr, m_tdata, m_tvalid, m_tlast, busy, done
    );
endinterface

// File: rtl/bram_burst_reader.sv
// Burst reader: fetches 64-bit BRAM words through a 2-word prefetch buffer.
// Each word is emitted as two 32-bit stream beats, upper half first.
module bram_burst_reader #(
    parameter int ADDR_W   = 10,
    parameter int LEN_W    = 9,
    parameter int BRAM_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    bram_burst_reader_if.master        bus,
    output logic [1:0]                 dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [LEN_W-1:0]    beats_left_q, beats_left_d;
    logic [LEN_W-1:0]    words_left_q, words_left_d;
    logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
    logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
    logic                half_sel_q, half_sel_d;
    logic [BRAM_LAT-1:0] infl_q, infl_d;
    logic [63:0]         buf_q [2];
    logic [63:0]         buf_d [2];
    logic                rd_ptr_q, rd_ptr_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic [1:0]          count_q, count_d;

    logic [2:0]          infl_cnt;
    logic [2:0]          occupancy;
    logic [LEN_W-1:0]    words_init;
    logic [63:0]         head;
    logic                tvalid, last_beat, hs, pop, capture, issue;

    assign tvalid     = (count_q != 2'd0);
    assign last_beat  = (beats_left_q == LEN_W'(1));
    assign hs         = tvalid & bus.m_tready;
    // An odd-length burst drops the lower half of its final word.
    assign pop        = hs & (half_sel_q | last_beat);
    assign capture    = infl_q[BRAM_LAT-1];
    assign words_init = {1'b0, bus.beat_len[LEN_W-1:1]} + LEN_W'(bus.beat_len[0]);
    assign head       = buf_q[rd_ptr_q];

    always_comb begin
        infl_cnt = 3'd0;
        for (int i = 0; i < BRAM_LAT; i++) begin
            infl_cnt = infl_cnt + {2'b00, infl_q[i]};
        end
    end

    // The word leaving this cycle frees its slot, which keeps back-to-back issue bubble-free.
    assign occupancy = {1'b0, count_q} + infl_cnt - {2'b00, pop};
    assign issue     = (state_q == RUN) && (words_left_q != '0) && (occupancy < 3'd2);

    assign bus.bram_en   = issue;
    assign bus.bram_addr = issue ? next_addr_q : bram_addr_q;
    assign bus.m_tdata   = half_sel_q ? head[31:0] : head[63:32];
    assign bus.m_tvalid  = tvalid;
    assign bus.m_tlast   = tvalid & last_beat;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign dbg_state     = state_q;

    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (capture) begin
            buf_d[wr_ptr_q] = bus.bram_rdata;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, capture} - {1'b0, pop};
        infl_d    = infl_q << 1;
        infl_d[0] = issue;
    end

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        words_left_d = words_left_q;
        next_addr_d  = next_addr_q;
        bram_addr_d  = bram_addr_q;
        half_sel_d   = half_sel_q;

        if (issue) begin
            words_left_d = words_left_q - LEN_W'(1);
            next_addr_d  = next_addr_q + ADDR_W'(1);
            bram_addr_d  = next_addr_q;
        end
        if (hs) begin
            beats_left_d = beats_left_q - LEN_W'(1);
            half_sel_d   = pop ? 1'b0 : ~half_sel_q;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    next_addr_d  = bus.base_addr;
                    beats_left_d = bus.beat_len;
                    words_left_d = words_init;
                    half_sel_d   = 1'b0;
                    state_d      = RUN;
                end
            end
            // A zero-length burst spends one busy cycle here before completing.
            RUN: begin
                if ((beats_left_q == '0) || (hs && last_beat)) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            beats_left_q <= '0;
            words_left_q <= '0;
            next_addr_q  <= '0;
            bram_addr_q  <= '0;
            half_sel_q   <= 1'b0;
            infl_q       <= '0;
            buf_q[0]     <= '0;
            buf_q[1]     <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            beats_left_q <= beats_left_d;
            words_left_q <= words_left_d;
            next_addr_q  <= next_addr_d;
            bram_addr_q  <= bram_addr_d;
            half_sel_q   <= half_sel_d;
            infl_q       <= infl_d;
            buf_q[0]     <= buf_d[0];
            buf_q[1]     <= buf_d[1];
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end
endmodule

// File: tb/tb_bram_burst_reader.sv
// Directed bench for bram_burst_reader: one instance with 1-cycle BRAM latency.
// A second instance has 2-cycle BRAM latency; both share one BRAM image.
module tb_bram_burst_reader;
    logic        clk;
    logic        rst_n;
    logic [1:0]  dbg1, dbg2;
    logic [63:0] mem [0:1023];
    logic [63:0] rd1_q, rd2_a, rd2_b;
    logic [31:0] exp_q [$];
    logic [31:0] rdy_pat;
    logic [31:0] t1_beats [4];
    logic [63:0] w;
    int          errors;
    int          checks;
    int          n_en;

    bram_burst_reader_if #(.ADDR_W(10), .LEN_W(9)) bus1 ();
    bram_burst_reader_if #(.ADDR_W(10), .LEN_W(9)) bus2 ();

    bram_burst_reader #(.ADDR_W(10), .LEN_W(9), .BRAM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state(dbg1)
    );
    bram_burst_reader #(.ADDR_W(10), .LEN_W(9), .BRAM_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .dbg_state(dbg2)
    );

    // Clock and BRAM models
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus1.bram_en) rd1_q <= mem[bus1.bram_addr];
        if (bus2.bram_en) rd2_a <= mem[bus2.bram_addr];
        rd2_b <= rd2_a;
    end
    assign bus1.bram_rdata = rd1_q;
    assign bus2.bram_rdata = rd2_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_en"},     64'(bus1.bram_en),   0);
        check({tag, "_addr"},   64'(bus1.bram_addr), 0);
        check({tag, "_tdata"},  64'(bus1.m_tdata),   0);
        check({tag, "_tvalid"}, 64'(bus1.m_tvalid),  0);
        check({tag, "_tlast"},  64'(bus1.m_tlast),   0);
        check({tag, "_busy"},   64'(bus1.busy),      0);
        check({tag, "_done"},   64'(bus1.done),      0);
        check({tag, "_state"},  64'(dbg1),           0);
        check({tag, "_tvalid2"}, 64'(bus2.m_tvalid), 0);
        check({tag, "_state2"}, 64'(dbg2),           0);
    endtask

    // Drives one burst on instance 1 and scores every beat against the BRAM image.
    task automatic run_burst(input logic [9:0] base, input logic [8:0] len, input bit stall,
                             input string tag, output int en_cnt);
        logic [63:0] wd;
        logic [31:0] got, prev_data;
        logic [9:0]  ea;
        int          words_popped, beat;
        bit          prev_stall, got_done;
        exp_q.delete();
        for (int i = 0; i < int'(len); i++) begin
            ea = base + 10'(i / 2);
            wd = mem[ea];
            exp_q.push_back((i % 2 == 1) ? wd[31:0] : wd[63:32]);
        end
        en_cnt = 0; words_popped = 0; beat = 0;
        prev_stall = 1'b0; got_done = 1'b0; prev_data = '0;
        @(negedge clk);
        bus1.base_addr = base; bus1.beat_len = len; bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            bus1.m_tready = stall ? rdy_pat[c % 32] : 1'b1;
            #1;
            if (bus1.bram_en) begin
                ea = base + 10'(en_cnt);
                check({tag, "_addr"}, 64'(bus1.bram_addr), 64'(ea));
                en_cnt++;
            end
            if (prev_stall) check({tag, "_hold"}, 64'(bus1.m_tdata), 64'(prev_data));
            if (bus1.m_tvalid && bus1.m_tready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_beat"}, 64'(beat), 64'(len));
                end else begin
                    got = exp_q.pop_front();
                    check({tag, "_data"}, 64'(bus1.m_tdata), 64'(got));
                    check({tag, "_tlast"}, 64'(bus1.m_tlast), 64'(exp_q.size() == 0));
                    if (beat % 2 == 1 || exp_q.size() == 0) words_popped++;
                end
                beat++;
            end
            check({tag, "_occ"}, 64'((en_cnt - words_popped) <= 2), 1);
            prev_stall = bus1.m_tvalid && !bus1.m_tready;
            prev_data  = bus1.m_tdata;
            if (bus1.done) begin
                got_done = 1'b1;
                check({tag, "_beats_at_done"}, 64'(beat), 64'(len));
                check({tag, "_busy_at_done"}, 64'(bus1.busy), 0);
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 64'(got_done), 1);
        check({tag, "_left"}, 64'(exp_q.size()), 0);
        bus1.m_tready = 1'b1;
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rdy_pat = 32'h6D3B_5A69;
        t1_beats[0] = 32'hAAAA_0001; t1_beats[1] = 32'hBBBB_0002;
        t1_beats[2] = 32'hCCCC_0003; t1_beats[3] = 32'hDDDD_0004;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = {32'(i) | 32'hA500_0000, 32'(i) ^ 32'h5A5A_5A5A};
        end
        mem[10'h010] = 64'hAAAA_0001_BBBB_0002;
        mem[10'h011] = 64'hCCCC_0003_DDDD_0004;
        mem[10'h3FF] = 64'h1111_2222_3333_4444;
        mem[10'h000] = 64'h5555_6666_7777_8888;

        rst_n = 1'b0;
        bus1.start = 1'b0; bus1.base_addr = '0; bus1.beat_len = '0; bus1.m_tready = 1'b1;
        bus2.start = 1'b0; bus2.base_addr = '0; bus2.beat_len = '0; bus2.m_tready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: 4-beat burst, exact cycle timing
        @(negedge clk);
        bus1.base_addr = 10'h010; bus1.beat_len = 9'd4; bus1.start = 1'b1;
        #1;
        check("t1_c0_busy", 64'(bus1.busy), 0);
        @(negedge clk);
        bus1.start = 1'b0;
        #1;
        check("t1_c1_busy", 64'(bus1.busy), 1);
        check("t1_c1_en", 64'(bus1.bram_en), 1);
        check("t1_c1_addr", 64'(bus1.bram_addr), 64'h010);
        check("t1_c1_tvalid", 64'(bus1.m_tvalid), 0);
        @(negedge clk);
        #1;
        check("t1_c2_en", 64'(bus1.bram_en), 1);
        check("t1_c2_addr", 64'(bus1.bram_addr), 64'h011);
        check("t1_c2_tvalid", 64'(bus1.m_tvalid), 0);
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            #1;
            check("t1_tvalid", 64'(bus1.m_tvalid), 1);
            check("t1_tdata", 64'(bus1.m_tdata), 64'(t1_beats[c-3]));
            check("t1_tlast", 64'(bus1.m_tlast), 64'(c == 6));
            check("t1_en_idle", 64'(bus1.bram_en), 0);
        end
        @(negedge clk);
        #1;
        check("t1_c7_done", 64'(bus1.done), 1);
        check("t1_c7_busy", 64'(bus1.busy), 0);
        check("t1_c7_tvalid", 64'(bus1.m_tvalid), 0);
        check("t1_c7_state", 64'(dbg1), 2);
        @(negedge clk);
        #1;
        check("t1_c8_done", 64'(bus1.done), 0);

        // Test 2: odd length across the address wrap
        run_burst(10'h3FF, 9'd3, 1'b0, "t2", n_en);
        check("t2_en_count", 64'(n_en), 2);

        // Test 3: 8 beats under a fixed back-pressure pattern
        run_burst(10'h040, 9'd8, 1'b1, "t3", n_en);
        check("t3_en_count", 64'(n_en), 4);

        // Test 4: zero length, plus starts while busy and in the done cycle
        @(negedge clk);
        bus1.base_addr = 10'h050; bus1.beat_len = 9'd0; bus1.start = 1'b1;
        @(negedge clk);
        bus1.base_addr = 10'h060; bus1.beat_len = 9'd4;
        #1;
        check("t4_c1_busy", 64'(bus1.busy), 1);
        check("t4_c1_en", 64'(bus1.bram_en), 0);
        check("t4_c1_tvalid", 64'(bus1.m_tvalid), 0);
        @(negedge clk);
        #1;
        check("t4_c2_done", 64'(bus1.done), 1);
        check("t4_c2_busy", 64'(bus1.busy), 0);
        check("t4_c2_en", 64'(bus1.bram_en), 0);
        @(negedge clk);
        bus1.start = 1'b0;
        #1;
        check("t4_c3_done", 64'(bus1.done), 0);
        check("t4_c3_busy", 64'(bus1.busy), 0);
        check("t4_c3_state", 64'(dbg1), 0);
        @(negedge clk);
        #1;
        check("t4_c4_busy", 64'(bus1.busy), 0);
        check("t4_c4_en", 64'(bus1.bram_en), 0);
        check("t4_c4_tvalid", 64'(bus1.m_tvalid), 0);

        // Test 5: reset during the third beat, then a fresh burst
        @(negedge clk);
        bus1.base_addr = 10'h020; bus1.beat_len = 9'd8; bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        w = mem[10'h021];
        check("t5_beat3_valid", 64'(bus1.m_tvalid), 1);
        check("t5_beat3_data", 64'(bus1.m_tdata), 64'(w[63:32]));
        rst_n = 1'b0;
        #1;
        chk_zero("t5_rst");
        repeat (2) begin
            @(negedge clk);
            #1;
            check("t5_no_done", 64'(bus1.done), 0);
            check("t5_no_busy", 64'(bus1.busy), 0);
        end
        rst_n = 1'b1;
        run_burst(10'h030, 9'd6, 1'b0, "t5_new", n_en);
        check("t5_en_count", 64'(n_en), 3);

        // Test 6: two-cycle BRAM latency, 16 beats back to back
        @(negedge clk);
        bus2.base_addr = 10'h080; bus2.beat_len = 9'd16; bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            #1;
            if (c < 4) begin
                check("t6_no_valid", 64'(bus2.m_tvalid), 0);
            end else if (c < 20) begin
                w = mem[10'h080 + 10'((c - 4) / 2)];
                check("t6_valid", 64'(bus2.m_tvalid), 1);
                check("t6_data", 64'(bus2.m_tdata), ((c - 4) % 2 == 1) ? 64'(w[31:0]) : 64'(w[63:32]));
                check("t6_tlast", 64'(bus2.m_tlast), 64'(c == 19));
            end else if (c == 20) begin
                check("t6_done", 64'(bus2.done), 1);
                check("t6_tvalid_end", 64'(bus2.m_tvalid), 0);
            end else begin
                check("t6_done_end", 64'(bus2.done), 0);
                check("t6_busy_end", 64'(bus2.busy), 0);
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
